// File: rtl/hazard_call_injector_pkg.sv
// Shared constants for the hazard CALL injector: opcode, FSM encoding,
// instruction field positions and the CALL word builder.
package hazard_call_injector_pkg;

  localparam logic [7:0] CALL_OPCODE_DEF = 8'hC4;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 24;
  localparam int VEC_MSB = 15;
  localparam int VEC_LSB = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_INJECT  = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;

  // Bits [23:16] are reserved and always zero in a synthesized CALL.
  function automatic logic [31:0] make_call(input logic [7:0] opc, input logic [15:0] vec);
    logic [31:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB] = opc;
    w[VEC_MSB:VEC_LSB] = vec;
    return w;
  endfunction

endpackage

// File: rtl/hazard_call_injector_if.sv
// Fetch-side handshake between the CALL injector (master) and the fetch mux (slave).
interface hazard_call_injector_if;
  logic        sel;
  logic [31:0] hazard_call_instruction;
  logic        stall;
  logic        flush;
  logic        ret_done;

  modport master (
    output sel, hazard_call_instruction,
    input  stall, flush, ret_done
  );

  modport slave (
    input  sel, hazard_call_instruction,
    output stall, flush, ret_done
  );
endinterface

// File: rtl/hazard_prio_enc.sv
// Lowest-set-bit priority encoder: index 0 wins.
module hazard_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/hazard_call_injector.sv
// Latches hazard request edges and injects a CALL to the winning source's vector.
// Define HAZARD_NEST_EN to allow higher-priority sources to preempt an active handler.
module hazard_call_injector
  import hazard_call_injector_pkg::*;
#(
  parameter int          NUM_SRC      = 8,
  parameter logic [7:0]  CALL_OPCODE  = CALL_OPCODE_DEF,
  parameter logic [15:0] VECTOR_BASE  = 16'h0040,
  parameter int          VECTOR_SHIFT = 4,
  parameter int          MAX_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC-1:0]     hazard_req,
  input  logic                   global_en,
  hazard_call_injector_if.master fif,
  output logic [NUM_SRC-1:0]     hazard_ack,
  output logic                   in_handler
);

  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1);

  logic [1:0]         state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               sel_q, sel_d;
  logic [31:0]        instr_q, instr_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic               inh_q, inh_d;

  logic               pend_vld;
  logic [IDX_W-1:0]   pend_idx;
  logic               accept;
  logic               preempt_ok;
  logic [NUM_SRC-1:0] clr;
  logic [15:0]        vec_d;

  hazard_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_enc (
    .req_i   (pend_q),
    .valid_o (pend_vld),
    .idx_o   (pend_idx)
  );

`ifdef HAZARD_NEST_EN
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

  logic [MAX_DEPTH-1:0][IDX_W-1:0] stack_q, stack_d;
  logic [IDX_W-1:0]                top_idx;

  // The stack holds every source whose CALL has been accepted; top = newest.
  always_comb begin
    top_idx = '0;
    stack_d = stack_q;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (depth_q == DEPTH_W'(k + 1)) top_idx = stack_q[k];
      if (accept && depth_q == DEPTH_W'(k)) stack_d[k] = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stack_q <= '0;
    else        stack_q <= stack_d;
  end

  assign preempt_ok = global_en && pend_vld && (depth_q < DEPTH_MAX) && (pend_idx < top_idx);
`else
  assign preempt_ok = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    depth_d = depth_q;
    accept  = 1'b0;
    clr     = '0;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (global_en && pend_vld) begin
          idx_d   = pend_idx;
          state_d = ST_INJECT;
        end
      end
      ST_INJECT: begin
        // flush and stall both keep the word up; only a clean cycle consumes it.
        if (!fif.flush && !fif.stall) begin
          accept  = 1'b1;
          clr     = SRC_ONE << idx_q;
          ack_d   = SRC_ONE << idx_q;
          depth_d = depth_q + 1'b1;
          state_d = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (fif.ret_done) begin
          depth_d = depth_q - 1'b1;
          if (depth_q == DEPTH_W'(1)) state_d = ST_IDLE;
        end else if (preempt_ok) begin
          idx_d   = pend_idx;
          state_d = ST_INJECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge on the bit being acknowledged survives the clear.
  assign pend_d  = (pend_q & ~clr) | (hazard_req & ~prev_q);
  assign vec_d   = VECTOR_BASE + (16'(idx_d) << VECTOR_SHIFT);
  assign sel_d   = (state_d == ST_INJECT);
  assign instr_d = sel_d ? make_call(CALL_OPCODE, vec_d) : 32'h0;
  assign inh_d   = (depth_d != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      prev_q  <= '0;
      idx_q   <= '0;
      depth_q <= '0;
      sel_q   <= 1'b0;
      instr_q <= 32'h0;
      ack_q   <= '0;
      inh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prev_q  <= hazard_req;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      sel_q   <= sel_d;
      instr_q <= instr_d;
      ack_q   <= ack_d;
      inh_q   <= inh_d;
    end
  end

  assign fif.sel                     = sel_q;
  assign fif.hazard_call_instruction = instr_q;
  assign hazard_ack                  = ack_q;
  assign in_handler                  = inh_q;

endmodule

// File: tb/tb_hazard_call_injector.sv
// Directed bench for hazard_call_injector: queue-based reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_hazard_call_injector;

`ifdef HAZARD_NEST_EN
  localparam int MD = 2;
`else
  localparam int MD = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       gen;
  logic [7:0] ack;
  logic       inh;

  hazard_call_injector_if fif();

  hazard_call_injector #(
    .NUM_SRC   (8),
    .MAX_DEPTH (MD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hazard_req (req),
    .global_en  (gen),
    .fif        (fif),
    .hazard_ack (ack),
    .in_handler (inh)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // Reference model: pending set, the source currently offered, and a list of active handlers.
  bit [7:0]    m_pend, m_prev, rise;
  int          m_offer = -1;
  int          m_act[$];
  int          lo;
  logic        e_sel  = 1'b0;
  logic [31:0] e_word = 32'h0;
  logic [7:0]  e_ack  = 8'h0;
  logic        e_inh  = 1'b0;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_offer = -1; m_act.delete();
      e_sel = 1'b0; e_word = 32'h0; e_ack = 8'h0; e_inh = 1'b0;
    end else begin
      rise   = req & ~m_prev;
      m_prev = req;
      e_ack  = 8'h0;
      lo     = lowest(m_pend);
      if (m_offer >= 0) begin
        if (!fif.flush && !fif.stall) begin
          e_ack = 8'(1) << m_offer;
          m_pend[m_offer] = 1'b0;
          m_act.push_back(m_offer);
          m_offer = -1;
        end
      end else if (m_act.size() == 0) begin
        if (gen && lo >= 0) m_offer = lo;
      end else if (fif.ret_done) begin
        void'(m_act.pop_back());
      end
`ifdef HAZARD_NEST_EN
      else if (gen && lo >= 0 && m_act.size() < MD && lo < m_act[$]) m_offer = lo;
`endif
      m_pend = m_pend | rise;
      e_sel  = (m_offer >= 0);
      e_word = e_sel ? {8'hC4, 8'h00, 16'h0040 + 16'(m_offer * 16)} : 32'h0;
      e_inh  = (m_act.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (fif.sel !== e_sel || fif.hazard_call_instruction !== e_word || ack !== e_ack || inh !== e_inh) begin
        n_bad++;
        $display("FAIL model cyc%0d: sel/word/ack/inh got %b/%h/%h/%b want %b/%h/%h/%b",
                 cyc, fif.sel, fif.hazard_call_instruction, ack, inh, e_sel, e_word, e_ack, e_inh);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic ret_pulse();
    fif.ret_done = 1'b1;
    step();
    fif.ret_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; gen = 1'b1;
    fif.stall = 1'b0; fif.flush = 1'b0; fif.ret_done = 1'b0;
    step(); step();
    chk("rst_sel",   32'(fif.sel), 32'h0);
    chk("rst_word",  fif.hazard_call_instruction, 32'h0);
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_inh",   32'(inh), 32'h0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    step();

    // 1: single source, two-cycle latency to sel, ack one cycle after accept
    req = 8'h08;
    step(); chk("t1_sel_early", 32'(fif.sel), 32'h0);
    step(); chk("t1_sel", 32'(fif.sel), 32'h1);
    chk("t1_word", fif.hazard_call_instruction, 32'hC400_0070);
    step(); chk("t1_ack", 32'(ack), 32'h08);
    chk("t1_inh", 32'(inh), 32'h1);
    req = '0;
    ret_pulse(); chk("t1_inh_clr", 32'(inh), 32'h0);

    // 2: simultaneous requests, priority then the loser after return
    req = 8'h22;
    step(); step(); chk("t2_word1", fif.hazard_call_instruction, 32'hC400_0050);
    step(); chk("t2_ack1", 32'(ack), 32'h02);
    ret_pulse(); step();
    chk("t2_word5", fif.hazard_call_instruction, 32'hC400_0090);
    step(); chk("t2_ack5", 32'(ack), 32'h20);
    req = '0;
    ret_pulse();

    // 3: three stall cycles, one flush, then accepted
    fif.stall = 1'b1; req = 8'h40;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_sel",  32'(fif.sel), 32'h1);
      chk("t3_word", fif.hazard_call_instruction, 32'hC400_00A0);
      chk("t3_noack", 32'(ack), 32'h0);
      fif.stall = (i < 3);
      fif.flush = (i == 3);
      step();
    end
    chk("t3_ack", 32'(ack), 32'h40);
    fif.stall = 1'b0; fif.flush = 1'b0; req = '0;
    ret_pulse();

    // 4: disabled injection keeps the request pending
    gen = 1'b0; req = 8'h04;
    step(); req = '0;
    for (int i = 0; i < 4; i++) begin
      step(); chk("t4_blocked", 32'(fif.sel), 32'h0);
    end
    gen = 1'b1;
    step(); chk("t4_word", fif.hazard_call_instruction, 32'hC400_0060);
    step(); chk("t4_ack", 32'(ack), 32'h04);
    ret_pulse();

    // 7: a new edge landing on the accept edge is kept pending
    req = 8'h08;
    step(); req = '0;
    step(); chk("t7_sel", 32'(fif.sel), 32'h1);
    req = 8'h08;
    step(); chk("t7_ack", 32'(ack), 32'h08);
    ret_pulse(); chk("t7_inh", 32'(inh), 32'h0);
    step(); chk("t7_reinject", fif.hazard_call_instruction, 32'hC400_0070);
    step(); chk("t7_ack2", 32'(ack), 32'h08);
    req = '0;
    ret_pulse();

    // 5: reset in the middle of an injection
    req = 8'h01; fif.stall = 1'b1;
    step(); step(); chk("t5_word", fif.hazard_call_instruction, 32'hC400_0040);
    rst_n = 1'b0; req = '0;
    step();
    chk("t5_sel",  32'(fif.sel), 32'h0);
    chk("t5_word0", fif.hazard_call_instruction, 32'h0);
    chk("t5_inh",  32'(inh), 32'h0);
    rst_n = 1'b1; fif.stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t5_no_pend", 32'(fif.sel), 32'h0);
    end

`ifdef HAZARD_NEST_EN
    // 6: preemption by a higher source, none by a lower one at max depth
    req = 8'h10;
    step(); step(); chk("t6_word4", fif.hazard_call_instruction, 32'hC400_0080);
    step(); chk("t6_ack4", 32'(ack), 32'h10);
    req = 8'h11;
    step(); step(); chk("t6_word0", fif.hazard_call_instruction, 32'hC400_0040);
    chk("t6_inh", 32'(inh), 32'h1);
    step(); chk("t6_ack0", 32'(ack), 32'h01);
    req = 8'h13;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t6_no_preempt", 32'(fif.sel), 32'h0);
    end
    fif.ret_done = 1'b1;
    step(); chk("t6_inh_mid", 32'(inh), 32'h1);
    step(); fif.ret_done = 1'b0;
    chk("t6_inh_clr", 32'(inh), 32'h0);
    step(); chk("t6_word1", fif.hazard_call_instruction, 32'hC400_0050);
    step(); chk("t6_ack1", 32'(ack), 32'h02);
    req = '0;
    ret_pulse();
`endif

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
